// File: rtl/spwm_demod.sv
// Sine-PWM demodulator: measures rise-to-rise period and high time of pwm_in and
// emits a signed sample per period. Optional glitch filter: define SPWM_DEMOD_FILTER_EN.
module spwm_demod #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 4096,
    parameter int FILT_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic [CNT_WIDTH:0]   sample_o,
    output logic                 valid_o,
    output logic                 timeout_o,
    output logic                 level_o,
    output logic                 locked_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 pwm_s;
    logic                 pwm_d_r;
    logic                 rise_r;
    logic [0:0]           state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] hcnt_r;
    logic [CNT_WIDTH-1:0] cnt_inc_s;
    logic [CNT_WIDTH-1:0] hcnt_inc_s;
    logic [CNT_WIDTH:0]   diff_s;
    logic                 timeout_s;
    logic [CNT_WIDTH-1:0] period_r;
    logic [CNT_WIDTH-1:0] high_r;
    logic [CNT_WIDTH:0]   sample_r;
    logic                 valid_r;
    logic                 timeout_r;
    logic                 level_r;
    logic                 locked_r;

    // Two-flop synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef SPWM_DEMOD_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic          filt_r;
    logic [FW-1:0] fcnt_r;

    // Glitch filter: follow the synchronized level only after FILT_LEN agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 1'b0;
            fcnt_r <= '0;
        end else if (sync2_r == filt_r) begin
            fcnt_r <= '0;
        end else if (fcnt_r == FW'(FILT_LEN - 1)) begin
            filt_r <= sync2_r;
            fcnt_r <= '0;
        end else begin
            fcnt_r <= fcnt_r + FW'(1);
        end
    end

    assign pwm_s = filt_r;
`else
    assign pwm_s = sync2_r;
`endif

    // Edge register; pwm_d_r stays aligned with rise_r so the counters see a consistent view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_d_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            pwm_d_r <= pwm_s;
            rise_r  <= pwm_s & ~pwm_d_r;
        end
    end

    // Saturating increments, signed sample and timeout decision.
    always_comb begin
        cnt_inc_s  = cnt_r;
        hcnt_inc_s = hcnt_r;
        if (cnt_r != CNT_MAX) begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end else begin
            cnt_inc_s = cnt_r;
        end
        if (hcnt_r != CNT_MAX) begin
            hcnt_inc_s = hcnt_r + CNT_ONE;
        end else begin
            hcnt_inc_s = hcnt_r;
        end
        diff_s    = {1'b0, hcnt_r} - {2'b00, cnt_r[CNT_WIDTH-1:1]};
        timeout_s = (state_r == ST_ARMED) && !rise_r && (cnt_r == TIMEOUT_C);
    end

    // Period/high counters; both restart at 1 so the rise cycle itself is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            hcnt_r <= '0;
        end else if (rise_r) begin
            cnt_r  <= CNT_ONE;
            hcnt_r <= CNT_ONE;
        end else begin
            cnt_r <= cnt_inc_s;
            if (pwm_d_r) begin
                hcnt_r <= hcnt_inc_s;
            end else begin
                hcnt_r <= hcnt_r;
            end
        end
    end

    // IDLE/ARMED control and output registers; a rise beats a simultaneous timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            period_r  <= '0;
            high_r    <= '0;
            sample_r  <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            level_r   <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_r) begin
                        state_r  <= ST_ARMED;
                        locked_r <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (rise_r) begin
                        period_r  <= cnt_r;
                        high_r    <= hcnt_r;
                        sample_r  <= diff_s;
                        valid_r   <= 1'b1;
                        timeout_r <= 1'b0;
                    end else if (timeout_s) begin
                        timeout_r <= 1'b1;
                        level_r   <= pwm_d_r;
                        state_r   <= ST_IDLE;
                        locked_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign period_o  = period_r;
    assign high_o    = high_r;
    assign sample_o  = sample_r;
    assign valid_o   = valid_r;
    assign timeout_o = timeout_r;
    assign level_o   = level_r;
    assign locked_o  = locked_r;

endmodule

// File: tb/tb_spwm_demod.sv
// Directed testbench for spwm_demod; expected values are hand-computed per waveform.
module tb_spwm_demod;

    localparam int CW = 16;
    localparam int TO = 4096;
    localparam int FL = 4;
`ifdef SPWM_DEMOD_FILTER_EN
    localparam int LAT = 4 + FL;
`else
    localparam int LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm_in;
    logic [CW-1:0] period_o;
    logic [CW-1:0] high_o;
    logic [CW:0]   sample_o;
    logic          valid_o;
    logic          timeout_o;
    logic          level_o;
    logic          locked_o;

    spwm_demod #(.CNT_WIDTH(CW), .TIMEOUT(TO), .FILT_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .period_o(period_o), .high_o(high_o), .sample_o(sample_o),
        .valid_o(valid_o), .timeout_o(timeout_o), .level_o(level_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rise_cyc = 0;
    int last_valid_cyc = 0;
    int to_cyc = 0;
    int dbl = 0;
    logic valid_prev = 1'b0;
    logic to_prev = 1'b0;
    int q_p[$];
    int q_h[$];
    int q_s[$];
    int q_l[$];
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe/timeout monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_o) begin
            q_p.push_back(int'(period_o));
            q_h.push_back(int'(high_o));
            q_s.push_back(int'($signed(sample_o)));
            q_l.push_back(cyc - rise_cyc);
            last_valid_cyc <= cyc;
            if (valid_prev) dbl <= dbl + 1;
        end
        if (timeout_o && !to_prev) to_cyc <= cyc;
        valid_prev <= valid_o;
        to_prev    <= timeout_o;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_q();
        q_p.delete(); q_h.delete(); q_s.delete(); q_l.delete();
    endtask

    // One period starting with a rise: h cycles high, p-h low. Called at a negedge.
    task automatic pwm_period(input int p, input int h);
        rise_cyc = cyc;
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic chk_entry(input string tag, input int i, input int p, input int h, input int s);
        if (q_p.size() > i) begin
            chk({tag, "_period"}, q_p[i], p);
            chk({tag, "_high"}, q_h[i], h);
            chk({tag, "_sample"}, q_s[i], s);
        end else begin
            chk({tag, "_missing"}, q_p.size(), i + 1);
        end
    endtask

    initial begin
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", int'(period_o), 0);
        chk("rst_high", int'(high_o), 0);
        chk("rst_sample", int'(sample_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_locked", int'(locked_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First rise arms only; two strobes follow.
        clr_q();
        repeat (3) pwm_period(1024, 512);
        chk("a_count", q_p.size(), 2);
        chk_entry("a0", 0, 1024, 512, 0);
        chk_entry("a1", 1, 1024, 512, 0);
        if (q_l.size() > 0) chk("a_latency", q_l[0], LAT);
        chk("a_locked", int'(locked_o), 1);

        // Duty sweep: positive and negative samples.
        clr_q();
        pwm_period(1024, 768);
        pwm_period(1024, 256);
        pwm_period(1024, 512);
        chk("b_count", q_p.size(), 3);
        chk_entry("b0", 0, 1024, 512, 0);
        chk_entry("b1", 1, 1024, 768, 256);
        chk_entry("b2", 2, 1024, 256, -256);
        chk("b_double_strobe", dbl, 0);

        // Stuck high -> timeout exactly TO cycles after the last latched rise.
        clr_q();
        rise_cyc = cyc;
        pwm_in = 1'b1;
        repeat (TO + 20) @(negedge clk);
        chk("c_count", q_p.size(), 1);
        chk("c_to_delay", to_cyc - last_valid_cyc, TO);
        chk("c_timeout", int'(timeout_o), 1);
        chk("c_level", int'(level_o), 1);
        chk("c_locked", int'(locked_o), 0);
        chk("c_hold_period", int'(period_o), 1024);
        chk("c_hold_high", int'(high_o), 512);
        chk("c_hold_sample", int'($signed(sample_o)), 0);
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        clr_q();
        pwm_period(100, 30);
        chk("c_rearm_count", q_p.size(), 0);
        chk("c_rearm_locked", int'(locked_o), 1);
        chk("c_sticky", int'(timeout_o), 1);

        // Reset in the middle of a period.
        rise_cyc = cyc;
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("d_rst_period", int'(period_o), 0);
        chk("d_rst_locked", int'(locked_o), 0);
        chk("d_rst_timeout", int'(timeout_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        clr_q();
        repeat (3) pwm_period(100, 30);
        chk("d_count", q_p.size(), 2);
        chk_entry("d0", 0, 100, 30, -20);
        chk_entry("d1", 1, 100, 30, -20);

        // Rise on exactly the timeout cycle wins.
        clr_q();
        pwm_period(TO, 100);
        pwm_period(100, 50);
        chk("e_count", q_p.size(), 2);
        chk_entry("e1", 1, TO, 100, 100 - TO / 2);
        chk("e_timeout", int'(timeout_o), 0);
        chk("e_locked", int'(locked_o), 1);

        // Two-cycle low glitch inside the high phase.
        clr_q();
        rise_cyc = cyc;
        pwm_in = 1'b1;
        repeat (200) @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        pwm_in = 1'b1;
        repeat (310) @(negedge clk);
        pwm_in = 1'b0;
        repeat (512) @(negedge clk);
        pwm_period(1024, 512);
        chk_entry("f0", 0, 100, 50, 0);
`ifdef SPWM_DEMOD_FILTER_EN
        chk("f_count", q_p.size(), 2);
        chk_entry("f1", 1, 1024, 512, 0);
`else
        chk("f_count", q_p.size(), 3);
        chk_entry("f1", 1, 202, 200, 99);
        chk_entry("f2", 2, 822, 310, -101);
`endif
        chk("f_double_strobe", dbl, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/spwm_demod.md
SPWM_DEMOD -- requirements
Module: spwm_demod

Interface
REQ-001 SHALL provide parameter CNT_WIDTH, default 16, the width of the period and high-time counters.
REQ-002 SHALL provide parameter TIMEOUT, default 4096, the number of cycles without a rising edge after which a timeout is declared; legal range 2..2**CNT_WIDTH-1.
REQ-003 SHALL provide parameter FILT_LEN, default 4, the number of consecutive equal samples the glitch filter requires (used only when the macro is set).
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pwm_in  input  1  asynchronous PWM waveform.
REQ-007 period_o  output  CNT_WIDTH  last measured period, rise to rise, in clk cycles.
REQ-008 high_o  output  CNT_WIDTH  last measured high time in clk cycles.
REQ-009 sample_o  output  CNT_WIDTH+1  signed sample, high_o minus (period_o>>1).
REQ-010 valid_o  output  1  one-cycle strobe; outputs updated this cycle.
REQ-011 timeout_o  output  1  sticky flag; no rising edge seen within TIMEOUT cycles.
REQ-012 level_o  output  1  stuck level at the timeout (1 = stuck high).
REQ-013 locked_o  output  1  high while the FSM is in ARMED.

Function
REQ-014 SHALL pass pwm_in through a 2-flop synchronizer to pwm_s; the filter (when present) follows it; a rise is pwm_s=1 with previous pwm_s=0.
REQ-015 SHALL implement FSM IDLE/ARMED: IDLE goes to ARMED on a rise; ARMED goes to IDLE on timeout; ARMED stays in ARMED on each rise.
REQ-016 On a rise, cnt_r SHALL load 1 and hcnt_r SHALL load 1; otherwise cnt_r increments every cycle, and hcnt_r increments on cycles with pwm_s=1.
REQ-017 On a rise in ARMED, period_o SHALL load cnt_r, high_o SHALL load hcnt_r, sample_o SHALL load the signed difference, valid_o SHALL pulse, and timeout_o SHALL clear.
REQ-018 A rise in IDLE SHALL only arm; it SHALL NOT produce a valid_o strobe.
REQ-019 Measured values SHALL equal the exact P and H of the pwm_in waveform; the constant pipeline delay SHALL NOT bias them.
REQ-020 Latency SHALL be as follows: valid_o is asserted 4 clk cycles after the first posedge that samples pwm_in high (2 synchronizer stages, edge register, output register), plus FILT_LEN cycles with the filter.
REQ-021 Timeout SHALL occur when cnt_r reaches TIMEOUT in ARMED with no rise that cycle: timeout_o=1, level_o=pwm_s, FSM to IDLE, no valid_o strobe, and period_o/high_o/sample_o hold.
REQ-022 cnt_r and hcnt_r SHALL saturate at 2**CNT_WIDTH-1 and SHALL never wrap.
REQ-023 If a rise and a timeout occur in the same cycle, the rise SHALL win: measurement is latched and there is no timeout.
REQ-024 Continuous high or low in IDLE SHALL leave all outputs unchanged.
REQ-025 sample_o SHALL be sign-extended; H=0 SHALL NOT be reachable in ARMED, since H is at least 1 per REQ-016.

Reset
REQ-026 On rst_n low, the FSM SHALL be IDLE and all counters, synchronizer and filter flops, and outputs SHALL be 0, including valid_o, timeout_o, level_o and locked_o.
REQ-027 Reset mid-measurement SHALL discard the partial period; the first rise after release SHALL only arm.

Configuration
REQ-028 Macro SPWM_DEMOD_FILTER_EN SHALL control the glitch filter: when defined, pwm_s changes only after FILT_LEN consecutive identical synchronized samples, adding FILT_LEN cycles of latency; when undefined, the filter is absent and pwm_s is the synchronizer output.

Verification
REQ-029 Reset, then P=1024, H=512, 3 periods -> first rise arms; 2 strobes with period_o=1024, high_o=512, sample_o=0.
REQ-030 P=1024, H=768, then H=256 -> sample_o=+256, then -256; valid_o exactly one cycle per period.
REQ-031 Locked, then pwm_in held high, TIMEOUT=4096 -> timeout_o=1, level_o=1, locked_o=0 exactly 4096 cycles after the last latched rise; outputs hold; next rise arms only.
REQ-032 Reset pulse mid-period, then P=100, H=30 -> no strobe from the first rise after release; following strobes give 100/30/-20.
REQ-033 2-cycle low glitch inside the high phase at P=1024 -> with SPWM_DEMOD_FILTER_EN, no extra strobe and values are exact; without it, an extra strobe occurs at the glitch's rising edge.
REQ-034 Rise arriving on exactly the TIMEOUT cycle -> measurement latched with period_o=TIMEOUT, and timeout_o stays 0.
